// File: rtl/sync_fifo_param_pkg.sv
// Shared constants and width helpers for the single-clock parametrised FIFO.
// Read-mode selectors and the pointer width function live here so the top and its users agree.
package sync_fifo_param_pkg;

    localparam int FWFT_OFF = 0;
    localparam int FWFT_ON  = 1;

    // Address width; pointers and the occupancy count carry one extra bit.
    function automatic int ptrWidth(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// Storage array for the FIFO: synchronous write port, asynchronous read port.
// Contents are deliberately not reset.
module sync_fifo_mem #(
    parameter int DEPTH      = 16,
    parameter int DATA_WIDTH = 8,
    parameter int AW         = $clog2(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [AW-1:0]         waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]         raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with registered or first-word-fall-through read mode,
// threshold flags, occupancy count, sticky error flags and synchronous flush.
module sync_fifo_param
    import sync_fifo_param_pkg::*;
#(
    parameter int DEPTH         = 16,
    parameter int DATA_WIDTH    = 8,
    parameter int FWFT          = FWFT_OFF,
    parameter int AFULL_THRESH  = DEPTH - 4,
    parameter int AEMPTY_THRESH = 2,
    localparam int PTR_WIDTH    = ptrWidth(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  w_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  r_en,
    output logic [DATA_WIDTH-1:0] data_out,
    input  logic                  flush,
    input  logic                  clr_err,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [PTR_WIDTH:0]    count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int CW = PTR_WIDTH + 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_THRESH);
    localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_THRESH);

    logic [CW-1:0]         wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d, count_q, count_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d, memRdata;
    logic                  ovf_q, ovf_d, unf_q, unf_d;
    logic                  wrAcc, rdAcc, isFull, isEmpty;

    assign isFull  = (count_q == DEPTH_C);
    assign isEmpty = (count_q == '0);

    // Flush wins over both requests in the same cycle.
    assign wrAcc = w_en & ~isFull & ~flush;
    assign rdAcc = r_en & ~isEmpty & ~flush;

    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        dout_d  = dout_q;
        if (flush) begin
            wrPtr_d = '0;
            rdPtr_d = '0;
            count_d = '0;
        end else begin
            if (wrAcc) wrPtr_d = wrPtr_q + CW'(1);
            if (rdAcc) rdPtr_d = rdPtr_q + CW'(1);
            if (wrAcc && !rdAcc) begin
                count_d = count_q + CW'(1);
            end else if (!wrAcc && rdAcc) begin
                count_d = count_q - CW'(1);
            end
        end
        if ((FWFT != FWFT_ON) && rdAcc) begin
            dout_d = memRdata;
        end
        // Set beats clear when both happen in the same cycle.
        ovf_d = (w_en & isFull) | (ovf_q & ~clr_err);
        unf_d = (r_en & isEmpty) | (unf_q & ~clr_err);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
            dout_q  <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
            dout_q  <= dout_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    sync_fifo_mem #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH),
        .AW         (PTR_WIDTH)
    ) u_mem (
        .clk_i   (clk),
        .we_i    (wrAcc),
        .waddr_i (wrPtr_q[PTR_WIDTH-1:0]),
        .wdata_i (data_in),
        .raddr_i (rdPtr_q[PTR_WIDTH-1:0]),
        .rdata_o (memRdata)
    );

    // In fall-through mode the output is forced to zero while empty so reset shows zero.
    assign data_out     = (FWFT == FWFT_ON) ? (isEmpty ? '0 : memRdata) : dout_q;
    assign full         = isFull;
    assign empty        = isEmpty;
    assign almost_full  = (count_q >= AFULL_C);
    assign almost_empty = (count_q <= AEMPTY_C);
    assign count        = count_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench: a registered-output and a fall-through FIFO driven in lockstep,
// compared every cycle against a queue-based model plus literal expectations.
module tb_sync_fifo_param;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wEn = 1'b0, rEn = 1'b0, flushIn = 1'b0, clrErr = 1'b0;
    logic [7:0] dataIn = 8'h00;

    logic [7:0] dout0, dout1;
    logic [4:0] count0, count1;
    logic       full0, empty0, afull0, aempty0, ovf0, unf0;
    logic       full1, empty1, afull1, aempty1, ovf1, unf1;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sync_fifo_param #(
        .DEPTH(16), .DATA_WIDTH(8), .FWFT(0), .AFULL_THRESH(12), .AEMPTY_THRESH(2)
    ) dut0 (
        .clk(clk), .rst_n(rst_n), .w_en(wEn), .data_in(dataIn), .r_en(rEn),
        .data_out(dout0), .flush(flushIn), .clr_err(clrErr), .full(full0),
        .empty(empty0), .almost_full(afull0), .almost_empty(aempty0),
        .count(count0), .overflow(ovf0), .underflow(unf0)
    );

    sync_fifo_param #(
        .DEPTH(16), .DATA_WIDTH(8), .FWFT(1), .AFULL_THRESH(12), .AEMPTY_THRESH(2)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .w_en(wEn), .data_in(dataIn), .r_en(rEn),
        .data_out(dout1), .flush(flushIn), .clr_err(clrErr), .full(full1),
        .empty(empty1), .almost_full(afull1), .almost_empty(aempty1),
        .count(count1), .overflow(ovf1), .underflow(unf1)
    );

    // Reference model: contents as a queue, flags from its size, registered read word.
    logic [7:0] modelQ[$];
    logic [7:0] mDout0;
    logic       mOvf, mUnf;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            modelQ.delete();
            mDout0 = 8'h00;
            mOvf   = 1'b0;
            mUnf   = 1'b0;
        end else begin
            mOvf = (wEn && modelQ.size() == 16) || (mOvf && !clrErr);
            mUnf = (rEn && modelQ.size() == 0) || (mUnf && !clrErr);
            if (flushIn) begin
                modelQ.delete();
            end else begin
                logic doWrite;
                doWrite = wEn && modelQ.size() < 16;
                if (rEn && modelQ.size() > 0) begin
                    mDout0 = modelQ.pop_front();
                end
                if (doWrite) modelQ.push_back(dataIn);
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        int sz;
        sz = modelQ.size();
        checkOutput("count0", 32'(count0), 32'(sz));
        checkOutput("count1", 32'(count1), 32'(sz));
        checkOutput("full0", 32'(full0), 32'(sz == 16));
        checkOutput("full1", 32'(full1), 32'(sz == 16));
        checkOutput("empty0", 32'(empty0), 32'(sz == 0));
        checkOutput("empty1", 32'(empty1), 32'(sz == 0));
        checkOutput("afull0", 32'(afull0), 32'(sz >= 12));
        checkOutput("afull1", 32'(afull1), 32'(sz >= 12));
        checkOutput("aempty0", 32'(aempty0), 32'(sz <= 2));
        checkOutput("aempty1", 32'(aempty1), 32'(sz <= 2));
        checkOutput("ovf0", 32'(ovf0), 32'(mOvf));
        checkOutput("ovf1", 32'(ovf1), 32'(mOvf));
        checkOutput("unf0", 32'(unf0), 32'(mUnf));
        checkOutput("unf1", 32'(unf1), 32'(mUnf));
        checkOutput("dout0", 32'(dout0), 32'(mDout0));
        if (sz > 0) checkOutput("dout1", 32'(dout1), 32'(modelQ[0]));
    end

    // Inputs change 1 time unit after a rising edge and are sampled by the next one.
    task automatic applyStimulus(input logic w, input logic [7:0] d, input logic r,
                                 input logic f, input logic c);
        wEn = w; dataIn = d; rEn = r; flushIn = f; clrErr = c;
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        checkOutput("resetCount", 32'(count0), 32'd0);
        checkOutput("resetEmpty", 32'(empty0), 32'd1);
        checkOutput("resetAempty", 32'(aempty0), 32'd1);
        checkOutput("resetFull", 32'(full0), 32'd0);
        checkOutput("resetDout", 32'(dout0), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
            if (i == 10) checkOutput("afullAt11", 32'(afull0), 32'd0);
            if (i == 11) checkOutput("afullAt12", 32'(afull0), 32'd1);
        end
        checkOutput("fillCount", 32'(count0), 32'd16);
        checkOutput("fillFull", 32'(full0), 32'd1);

        applyStimulus(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
        checkOutput("ovfCount", 32'(count0), 32'd16);
        checkOutput("ovfSet", 32'(ovf0), 32'd1);

        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
            checkOutput("drainData", 32'(dout0), 32'(i));
        end
        checkOutput("drainEmpty", 32'(empty0), 32'd1);

        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        checkOutput("unfSet", 32'(unf0), 32'd1);
        checkOutput("unfHoldDout", 32'(dout0), 32'h0F);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        checkOutput("clrOvf", 32'(ovf0), 32'd0);
        checkOutput("clrUnf", 32'(unf0), 32'd0);

        for (int i = 0; i < 16; i++) applyStimulus(1'b1, 8'(8'h20 + i), 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h99, 1'b1, 1'b0, 1'b0);
        checkOutput("rwFullCount", 32'(count0), 32'd15);
        checkOutput("rwFullOvf", 32'(ovf0), 32'd1);
        checkOutput("rwFullDout", 32'(dout0), 32'h20);
        for (int i = 0; i < 15; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        checkOutput("noDropped99", 32'(dout0), 32'h2F);
        applyStimulus(1'b1, 8'h77, 1'b1, 1'b0, 1'b0);
        checkOutput("rwEmptyCount", 32'(count0), 32'd1);
        checkOutput("rwEmptyUnf", 32'(unf0), 32'd1);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        checkOutput("read77", 32'(dout0), 32'h77);

        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            applyStimulus(1'b1, 8'(8'h50 + i), 1'b1, 1'b0, 1'b0);
            checkOutput("steadyCount", 32'(count0), 32'd8);
            checkOutput("steadyData", 32'(dout0), (i < 8) ? 32'(8'h40 + i) : 32'(8'h50 + i - 8));
        end
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        applyStimulus(1'b1, 8'h5C, 1'b0, 1'b0, 1'b0);
        checkOutput("fwftData", 32'(dout1), 32'h5C);
        checkOutput("fwftNotEmpty", 32'(empty1), 32'd0);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        checkOutput("fwftPopEmpty", 32'(empty1), 32'd1);

        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) applyStimulus(1'b1, 8'(8'h60 + i), 1'b0, 1'b0, 1'b0);
        checkOutput("preFlushCount", 32'(count0), 32'd9);
        applyStimulus(1'b1, 8'hEE, 1'b0, 1'b1, 1'b0);
        checkOutput("flushCount", 32'(count0), 32'd0);
        checkOutput("flushEmpty", 32'(empty0), 32'd1);
        checkOutput("flushKeepsUnf", 32'(unf0), 32'd1);
        checkOutput("flushKeepsDout", 32'(dout0), 32'h5C);
        applyStimulus(1'b1, 8'h31, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        checkOutput("postFlushData", 32'(dout0), 32'h31);

        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 8'(8'h70 + i), 1'b0, 1'b0, 1'b0);
        wEn = 1'b1; dataIn = 8'h7F;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("asyncRstCount", 32'(count0), 32'd0);
        checkOutput("asyncRstEmpty", 32'(empty0), 32'd1);
        checkOutput("asyncRstUnf", 32'(unf0), 32'd0);
        checkOutput("asyncRstDout", 32'(dout0), 32'd0);
        checkOutput("asyncRstDout1", 32'(dout1), 32'd0);
        wEn = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        applyStimulus(1'b1, 8'hC3, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        checkOutput("postRstData", 32'(dout0), 32'hC3);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
